pc_seq: RTL and testbench
=========================

PC_SEQ -- requirements
Module: pc_seq

Interface
REQ-001 Parameter WIDTH, default 16, PC and address width in bits.
REQ-002 Parameter RAS_DEPTH, default 8, return-address-stack entries (power of two, 2..64).
REQ-003 Parameter RESET_VECTOR, default 0, PC value loaded on reset.
REQ-004 Parameter IRQ_VECTOR, default 16'h0010, interrupt entry address (used only with PC_IRQ_EN).
REQ-005 clk  in  1  single clock, all state updates on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 stall  in  1  hold PC and stack unchanged this cycle.
REQ-008 jump  in  1  absolute load of jump_addr.
REQ-009 jump_addr  in  WIDTH  absolute target.
REQ-010 branch  in  1  relative branch.
REQ-011 branch_off  in  WIDTH  two's-complement offset added to pc_plus_one.
REQ-012 call  in  1  push pc_plus_one, then load jump_addr.
REQ-013 ret  in  1  pop stack top into PC.
REQ-014 resume  in  1  leave HALT state.
REQ-015 irq  in  1  interrupt request, level-sensitive (present only with PC_IRQ_EN).
REQ-016 reti  in  1  return from interrupt (present only with PC_IRQ_EN).
REQ-017 pc  out  WIDTH  current PC, registered.
REQ-018 pc_plus_one  out  WIDTH  pc + 1 modulo 2^WIDTH, combinational.
REQ-019 ras_empty, ras_full  out  1 each  stack occupancy flags.
REQ-020 err  out  1  sticky stack overflow/underflow flag.
REQ-021 halted  out  1  high in HALT state.
REQ-022 in_isr  out  1  high while servicing an interrupt (PC_IRQ_EN only).

Function
REQ-023 States RUN and HALT; RUN->HALT on call with ras_full or ret with ras_empty; HALT->RUN on resume.
REQ-024 In RUN, one action per cycle, priority: stall > irq > reti > ret > call > jump > branch > increment.
REQ-025 Increment: pc <= pc_plus_one; all PC arithmetic wraps modulo 2^WIDTH (0xFFFF -> 0x0000 at WIDTH 16).
REQ-026 Branch: pc <= pc_plus_one + branch_off, wraps, sign carried by two's complement.
REQ-027 Call: push pc_plus_one and pc <= jump_addr in the same cycle; pushed value visible at next ret.
REQ-028 Ret: pc <= top entry, pointer decrements; one-cycle latency from ret to new pc.
REQ-029 Overflow (call, ras_full) and underflow (ret, ras_empty): no push/pop, pc unchanged, err set, enter HALT.
REQ-030 In HALT: pc, stack and flags held; all control inputs except resume and rst ignored; err persists across resume.
REQ-031 ras_full = (count == RAS_DEPTH); ras_empty = (count == 0); flags registered with count.
REQ-032 Stall overrides every action including irq; a pending level irq is taken on the first unstalled cycle.

Reset
REQ-033 On rst: pc = RESET_VECTOR, stack count 0, ras_empty 1, ras_full 0, err 0, halted 0, in_isr 0, state RUN; rst overrides all inputs including mid-call/ret.

Configuration
REQ-034 Macro PC_IRQ_EN defined: irq/reti/in_isr ports exist; irq while in_isr = 0 pushes pc (not pc_plus_one) onto the stack, pc <= IRQ_VECTOR, in_isr <= 1; irq ignored while in_isr = 1; reti pops into pc and clears in_isr; irq with ras_full behaves as overflow per REQ-029.
REQ-035 Macro PC_IRQ_EN undefined: irq/reti/in_isr ports absent, no interrupt logic, remaining behaviour identical.

Structure
REQ-036 Shared package pc_pkg holds the state enum (RUN, HALT) and default vector constants.
REQ-037 Sub-module ras_stack (parametrised WIDTH, RAS_DEPTH; push, pop, top, count, full, empty) holds the return stack; no other sub-modules.

Verification
REQ-038 rst high one cycle, then 3 idle cycles -> pc 0x0000, 0x0001, 0x0002, 0x0003; pc_plus_one = pc + 1.
REQ-039 pc 0x0005, branch_off 0xFFFC -> pc 0x0002; pc 0xFFFF increment -> pc 0x0000.
REQ-040 pc 0x0010, call jump_addr 0x0100, then ret -> pc 0x0100 then 0x0011, ras_empty back to 1.
REQ-041 RAS_DEPTH 8: 9 nested calls -> 9th sets err and halted, pc unchanged; resume -> RUN, err still 1; ret on empty -> HALT.
REQ-042 PC_IRQ_EN, pc 0x0020, irq with stall high 2 cycles -> pc held 0x0020; stall low -> pc 0x0010, in_isr 1; second irq ignored; reti -> pc 0x0020, in_isr 0.
REQ-043 rst asserted same cycle as call -> pc RESET_VECTOR, ras_empty 1, no push.

Source files
------------

// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared state enum and default vectors for the pc sequencer
package pc_pkg;

  // Sequencer run state; HALT is entered on stack overflow/underflow
  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } pc_state_e;

  localparam int unsigned DEF_RESET_VECTOR = 32'h0000_0000;
  localparam int unsigned DEF_IRQ_VECTOR   = 32'h0000_0010;

endpackage

// File: rtl/ras_stack.sv
// rtl/ras_stack.sv - return-address stack with registered occupancy flags
module ras_stack
  import pc_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int RAS_DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           push_data,
  output logic [WIDTH-1:0]           top,
  output logic [$clog2(RAS_DEPTH):0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [RAS_DEPTH];
  logic [WIDTH-1:0] mem_d [RAS_DEPTH];
  logic [CW-1:0]    count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic [CW-1:0]    top_idx;

  // Entry count-1 is the top; the index is only meaningful when not empty
  assign top_idx = count_q - CW'(1);
  assign top     = mem_q[top_idx[PW-1:0]];
  assign count   = count_q;
  assign full    = full_q;
  assign empty   = empty_q;

  // Next stack contents and count; push into a full or pop from an empty stack is a no-op
  always_comb begin
    mem_d   = mem_q;
    count_d = count_q;
    if (push && !full_q) begin
      mem_d[count_q[PW-1:0]] = push_data;
      count_d                = count_q + CW'(1);
    end else if (pop && !empty_q) begin
      count_d = count_q - CW'(1);
    end
    full_d  = (count_d == CW'(RAS_DEPTH));
    empty_d = (count_d == '0);
  end

  // Count and flags register together so the flags always match the count
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      count_q <= count_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  // Storage needs no reset: entries above the count are never read
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/pc_seq.sv
// rtl/pc_seq.sv - program counter sequencer with return stack; PC_IRQ_EN adds interrupt entry/return
module pc_seq
  import pc_pkg::*;
#(
  parameter int              WIDTH        = 16,
  parameter int              RAS_DEPTH    = 8,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(DEF_RESET_VECTOR),
  parameter logic [WIDTH-1:0] IRQ_VECTOR   = WIDTH'(DEF_IRQ_VECTOR)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             jump,
  input  logic [WIDTH-1:0] jump_addr,
  input  logic             branch,
  input  logic [WIDTH-1:0] branch_off,
  input  logic             call,
  input  logic             ret,
  input  logic             resume,
`ifdef PC_IRQ_EN
  input  logic             irq,
  input  logic             reti,
  output logic             in_isr,
`endif
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus_one,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             err,
  output logic             halted
);

  pc_state_e        state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic             err_q, err_d;
  logic             push, pop;
  logic [WIDTH-1:0] push_data;
  logic [WIDTH-1:0] ras_top;
  logic [$clog2(RAS_DEPTH):0] ras_count_unused;

`ifdef PC_IRQ_EN
  logic in_isr_q, in_isr_d;
  assign in_isr = in_isr_q;
`else
  logic unused_irq_vector;
  assign unused_irq_vector = ^IRQ_VECTOR;
`endif

  assign pc          = pc_q;
  assign pc_plus_one = pc_q + WIDTH'(1);
  assign err         = err_q;
  assign halted      = (state_q == HALT);

  ras_stack #(
    .WIDTH     (WIDTH),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .push_data (push_data),
    .top       (ras_top),
    .count     (ras_count_unused),
    .full      (ras_full),
    .empty     (ras_empty)
  );

  // Select exactly one action per cycle in priority order; faults freeze the PC and halt
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    err_d     = err_q;
    push      = 1'b0;
    pop       = 1'b0;
    push_data = pc_plus_one;
`ifdef PC_IRQ_EN
    in_isr_d  = in_isr_q;
`endif
    if (state_q == HALT) begin
      if (resume) begin
        state_d = RUN;
      end
    end else if (stall) begin
      pc_d = pc_q;
`ifdef PC_IRQ_EN
    end else if (irq && !in_isr_q) begin
      if (ras_full) begin
        err_d   = 1'b1;
        state_d = HALT;
      end else begin
        push      = 1'b1;
        push_data = pc_q;
        pc_d      = IRQ_VECTOR;
        in_isr_d  = 1'b1;
      end
    end else if (reti) begin
      if (ras_empty) begin
        err_d   = 1'b1;
        state_d = HALT;
      end else begin
        pop      = 1'b1;
        pc_d     = ras_top;
        in_isr_d = 1'b0;
      end
`endif
    end else if (ret) begin
      if (ras_empty) begin
        err_d   = 1'b1;
        state_d = HALT;
      end else begin
        pop  = 1'b1;
        pc_d = ras_top;
      end
    end else if (call) begin
      if (ras_full) begin
        err_d   = 1'b1;
        state_d = HALT;
      end else begin
        push = 1'b1;
        pc_d = jump_addr;
      end
    end else if (jump) begin
      pc_d = jump_addr;
    end else if (branch) begin
      pc_d = pc_plus_one + branch_off;
    end else begin
      pc_d = pc_plus_one;
    end
  end

  // Sequencer state registers; reset wins over any in-flight action
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RUN;
      pc_q     <= RESET_VECTOR;
      err_q    <= 1'b0;
`ifdef PC_IRQ_EN
      in_isr_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      err_q    <= err_d;
`ifdef PC_IRQ_EN
      in_isr_q <= in_isr_d;
`endif
    end
  end

endmodule

// File: tb/tb_pc_seq.sv
// tb/tb_pc_seq.sv - vector table, corner sequences and randomized model check for pc_seq
module tb_pc_seq;

  localparam int DEPTH = 8;
  localparam logic [15:0] IRQV = 16'h0010;

  logic        clk = 1'b0;
  logic        rst, stall, jump, branch, call, ret, resume;
  logic [15:0] jump_addr, branch_off;
  logic [15:0] pc, pc_plus_one;
  logic        ras_empty, ras_full, err, halted;
`ifdef PC_IRQ_EN
  logic        irq, reti, in_isr;
`endif

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pc_seq #(
    .WIDTH        (16),
    .RAS_DEPTH    (DEPTH),
    .RESET_VECTOR (16'h0000),
    .IRQ_VECTOR   (IRQV)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .jump        (jump),
    .jump_addr   (jump_addr),
    .branch      (branch),
    .branch_off  (branch_off),
    .call        (call),
    .ret         (ret),
    .resume      (resume),
`ifdef PC_IRQ_EN
    .irq         (irq),
    .reti        (reti),
    .in_isr      (in_isr),
`endif
    .pc          (pc),
    .pc_plus_one (pc_plus_one),
    .ras_empty   (ras_empty),
    .ras_full    (ras_full),
    .err         (err),
    .halted      (halted)
  );

  typedef struct {
    logic        s, j, b, c, r, res;
    logic [15:0] ja, bo;
    logic [15:0] e_pc;
    logic        e_empty, e_full, e_err, e_halt;
  } vec_t;

  vec_t tbl[$];

  // behavioural reference: the stack is a plain queue of return addresses
  logic [15:0] m_pc;
  logic [15:0] m_stack[$];
  logic        m_err, m_halt, m_isr;

  function automatic vec_t mk(logic s, logic j, logic b, logic c, logic r, logic res,
                              logic [15:0] ja, logic [15:0] bo, logic [15:0] e_pc,
                              logic e_empty, logic e_full, logic e_err, logic e_halt);
    vec_t v;
    v.s = s; v.j = j; v.b = b; v.c = c; v.r = r; v.res = res;
    v.ja = ja; v.bo = bo; v.e_pc = e_pc;
    v.e_empty = e_empty; v.e_full = e_full; v.e_err = e_err; v.e_halt = e_halt;
    return v;
  endfunction

  task automatic set_idle();
    rst = 1'b0; stall = 1'b0; jump = 1'b0; branch = 1'b0; call = 1'b0;
    ret = 1'b0; resume = 1'b0; jump_addr = 16'h0; branch_off = 16'h0;
`ifdef PC_IRQ_EN
    irq = 1'b0; reti = 1'b0;
`endif
  endtask

  task automatic check(string name, logic [15:0] e_pc, logic e_empty, logic e_full,
                       logic e_err, logic e_halt, logic e_isr);
    logic [15:0] e_ppo;
    logic        a_isr;
    e_ppo = e_pc + 16'd1;
`ifdef PC_IRQ_EN
    a_isr = in_isr;
`else
    a_isr = e_isr;
`endif
    n_vec++;
    if (pc !== e_pc || pc_plus_one !== e_ppo || ras_empty !== e_empty || ras_full !== e_full ||
        err !== e_err || halted !== e_halt || a_isr !== e_isr) begin
      n_bad++;
      $display("FAIL %s: got pc=%h ppo=%h empty=%b full=%b err=%b halted=%b isr=%b, need pc=%h ppo=%h empty=%b full=%b err=%b halted=%b isr=%b",
               name, pc, pc_plus_one, ras_empty, ras_full, err, halted, a_isr,
               e_pc, e_ppo, e_empty, e_full, e_err, e_halt, e_isr);
    end
  endtask

  task automatic edge_wait();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic s, logic j, logic [15:0] ja, logic b, logic [15:0] bo,
                       logic c, logic r, logic res);
    @(negedge clk);
    set_idle();
    stall = s; jump = j; jump_addr = ja; branch = b; branch_off = bo;
    call = c; ret = r; resume = res;
  endtask

  function automatic void fault();
    m_err  = 1'b1;
    m_halt = 1'b1;
  endfunction

  function automatic void model_step();
    if (rst) begin
      m_pc = 16'h0000; m_stack.delete(); m_err = 1'b0; m_halt = 1'b0; m_isr = 1'b0;
      return;
    end
    if (m_halt) begin
      if (resume) m_halt = 1'b0;
      return;
    end
    if (stall) return;
`ifdef PC_IRQ_EN
    if (irq && !m_isr) begin
      if (m_stack.size() == DEPTH) fault();
      else begin m_stack.push_back(m_pc); m_pc = IRQV; m_isr = 1'b1; end
      return;
    end
    if (reti) begin
      if (m_stack.size() == 0) fault();
      else begin m_pc = m_stack.pop_back(); m_isr = 1'b0; end
      return;
    end
`endif
    if (ret) begin
      if (m_stack.size() == 0) fault();
      else m_pc = m_stack.pop_back();
    end else if (call) begin
      if (m_stack.size() == DEPTH) fault();
      else begin m_stack.push_back(m_pc + 16'd1); m_pc = jump_addr; end
    end else if (jump) begin
      m_pc = jump_addr;
    end else if (branch) begin
      m_pc = m_pc + 16'd1 + branch_off;
    end else begin
      m_pc = m_pc + 16'd1;
    end
  endfunction

  initial begin
    logic [15:0] exp_ret;
    //         s  j  b  c  r  res ja        bo        pc        em f  er h
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0001, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0002, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0003, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 16'h0004, 16'h0000, 16'h0004, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0005, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 16'h0000, 16'hFFFC, 16'h0002, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 16'h0010, 16'h0000, 16'h0010, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 16'h0100, 16'h0000, 16'h0100, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 16'h0000, 16'h0000, 16'h0011, 1, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 16'h0777, 16'h0000, 16'h0011, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 16'hFFFF, 16'h0000, 16'hFFFF, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 16'h0000, 16'h0000, 16'h0000, 1, 0, 1, 1));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 16'h0055, 16'h0000, 16'h0000, 1, 0, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 16'h0000, 16'h0000, 16'h0000, 1, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0001, 1, 0, 1, 0));
    tbl.push_back(mk(0, 1, 1, 1, 0, 0, 16'h0200, 16'h0040, 16'h0200, 0, 0, 1, 0));
    tbl.push_back(mk(0, 1, 0, 1, 1, 0, 16'h0300, 16'h0000, 16'h0002, 1, 0, 1, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 16'h0000, 16'h0010, 16'h0013, 1, 0, 1, 0));
    tbl.push_back(mk(1, 0, 0, 0, 1, 0, 16'h0000, 16'h0000, 16'h0013, 1, 0, 1, 0));

    set_idle();
    rst = 1'b1;
    edge_wait();
    check("reset", 16'h0000, 1, 0, 0, 0, 0);

    foreach (tbl[i]) begin
      drive(tbl[i].s, tbl[i].j, tbl[i].ja, tbl[i].b, tbl[i].bo, tbl[i].c, tbl[i].r, tbl[i].res);
      edge_wait();
      check($sformatf("vec%0d", i), tbl[i].e_pc, tbl[i].e_empty, tbl[i].e_full,
            tbl[i].e_err, tbl[i].e_halt, 0);
    end

    // nested calls up to overflow, resume, unwind, then underflow
    @(negedge clk); set_idle(); rst = 1'b1;
    edge_wait();
    for (int k = 0; k < DEPTH; k++) begin
      drive(0, 0, 16'(16'h0100 + k * 16), 0, 16'h0, 1, 0, 0);
      edge_wait();
      check($sformatf("call%0d", k), 16'(16'h0100 + k * 16), 0, (k == DEPTH - 1), 0, 0, 0);
    end
    drive(0, 0, 16'h0900, 0, 16'h0, 1, 0, 0);
    edge_wait();
    check("overflow", 16'h0170, 0, 1, 1, 1, 0);
    drive(0, 0, 16'h0, 0, 16'h0, 0, 0, 1);
    edge_wait();
    check("resume", 16'h0170, 0, 1, 1, 0, 0);
    for (int k = DEPTH - 1; k >= 0; k--) begin
      exp_ret = (k == 0) ? 16'h0001 : 16'(16'h0100 + (k - 1) * 16 + 1);
      drive(0, 0, 16'h0, 0, 16'h0, 0, 1, 0);
      edge_wait();
      check($sformatf("ret%0d", k), exp_ret, (k == 0), 0, 1, 0, 0);
    end
    drive(0, 0, 16'h0, 0, 16'h0, 0, 1, 0);
    edge_wait();
    check("underflow", 16'h0001, 1, 0, 1, 1, 0);

    // reset during a call: nothing may be pushed
    drive(0, 0, 16'h0300, 0, 16'h0, 1, 0, 0);
    rst = 1'b1;
    edge_wait();
    check("rst_call", 16'h0000, 1, 0, 0, 0, 0);
    drive(0, 0, 16'h0, 0, 16'h0, 0, 1, 0);
    edge_wait();
    check("rst_nopush", 16'h0000, 1, 0, 1, 1, 0);

`ifdef PC_IRQ_EN
    @(negedge clk); set_idle(); rst = 1'b1;
    edge_wait();
    drive(0, 1, 16'h0020, 0, 16'h0, 0, 0, 0);
    edge_wait();
    check("irq_setup", 16'h0020, 1, 0, 0, 0, 0);
    for (int k = 0; k < 2; k++) begin
      drive(1, 0, 16'h0, 0, 16'h0, 0, 0, 0);
      irq = 1'b1;
      edge_wait();
      check("irq_stall", 16'h0020, 1, 0, 0, 0, 0);
    end
    drive(0, 0, 16'h0, 0, 16'h0, 0, 0, 0);
    irq = 1'b1;
    edge_wait();
    check("irq_enter", 16'h0010, 0, 0, 0, 0, 1);
    drive(0, 0, 16'h0, 0, 16'h0, 0, 0, 0);
    irq = 1'b1;
    edge_wait();
    check("irq_nested", 16'h0011, 0, 0, 0, 0, 1);
    drive(0, 0, 16'h0, 0, 16'h0, 0, 0, 0);
    reti = 1'b1;
    edge_wait();
    check("reti", 16'h0020, 1, 0, 0, 0, 0);
`endif

    // randomized traffic against the queue-based model
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      set_idle();
      rst        = (n == 0) || ($urandom_range(199) == 0);
      stall      = ($urandom_range(9) == 0);
      ret        = ($urandom_range(5) == 0);
      call       = ($urandom_range(4) == 0);
      jump       = ($urandom_range(7) == 0);
      branch     = ($urandom_range(3) == 0);
      resume     = ($urandom_range(3) == 0);
      jump_addr  = 16'($urandom);
      branch_off = 16'($urandom);
`ifdef PC_IRQ_EN
      irq        = ($urandom_range(9) == 0);
      reti       = ($urandom_range(7) == 0);
`endif
      model_step();
      edge_wait();
      check($sformatf("rand%0d", n), m_pc, (m_stack.size() == 0), (m_stack.size() == DEPTH),
            m_err, m_halt, m_isr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
